// File: rtl/md_k2h_packer.sv
// MD kernel result stage: packs 128-bit particle records four-per-beat
// onto the 512-bit k2h AXI4-Stream host link, one frame per start pulse.
module md_k2h_packer #(
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int REC_WIDTH             = 128,
  parameter int STREAMING_TDEST_WIDTH = 16,
  parameter int CNT_WIDTH             = 32
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_records,
  input  logic [STREAMING_TDEST_WIDTH-1:0] dest_id,
  output logic                             busy,
  output logic                             done,
  input  logic [REC_WIDTH-1:0]             s_rec_tdata,
  input  logic                             s_rec_tvalid,
  output logic                             s_rec_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]      M_AXIS_k2h_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0]    M_AXIS_k2h_tkeep,
  output logic                             M_AXIS_k2h_tvalid,
  output logic                             M_AXIS_k2h_tlast,
  output logic [STREAMING_TDEST_WIDTH-1:0] M_AXIS_k2h_tdest,
  input  logic                             M_AXIS_k2h_tready
);

  localparam int LANES = 4;
  localparam int KW    = AXIS_TDATA_WIDTH / 8;
  localparam int LKW   = REC_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_DRAIN
  } state_e;

  state_e                           state_q, state_d;
  logic [CNT_WIDTH-1:0]             rem_q, rem_d;
  logic [1:0]                       slot_q, slot_d;
  logic [AXIS_TDATA_WIDTH-1:0]      acc_q, acc_d;
  logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic [AXIS_TDATA_WIDTH-1:0]      tdata_q, tdata_d;
  logic [KW-1:0]                    tkeep_q, tkeep_d;
  logic                             tvalid_q, tvalid_d;
  logic                             tlast_q, tlast_d;

  logic                             rec_rdy;
  logic                             rec_acc;
  logic                             last_rec;
  logic [AXIS_TDATA_WIDTH-1:0]      acc_nxt;

  // Output register is free when empty or being drained this cycle.
  assign rec_rdy  = (state_q == S_PACK) && (!tvalid_q || M_AXIS_k2h_tready);
  assign rec_acc  = rec_rdy && s_rec_tvalid;
  assign last_rec = (rem_q == CNT_WIDTH'(1));

  always_comb begin
    acc_nxt = (slot_q == 2'd0) ? '0 : acc_q;
    acc_nxt[slot_q*REC_WIDTH +: REC_WIDTH] = s_rec_tdata;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    slot_d   = slot_q;
    acc_d    = acc_q;
    dest_d   = dest_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;

    if (tvalid_q && M_AXIS_k2h_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          dest_d = dest_id;
          rem_d  = num_records;
          slot_d = 2'd0;
          busy_d = 1'b1;
          if (num_records == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PACK;
          end
        end
      end
      S_PACK: begin
        if (rec_acc) begin
          acc_d  = acc_nxt;
          rem_d  = rem_q - CNT_WIDTH'(1);
          slot_d = slot_q + 2'd1;
          if (slot_q == 2'd3 || last_rec) begin
            tdata_d  = acc_nxt;
            tvalid_d = 1'b1;
            tlast_d  = last_rec;
            for (int l = 0; l < LANES; l++) begin
              tkeep_d[l*LKW +: LKW] = (l <= int'(slot_q)) ? '1 : '0;
            end
            if (last_rec) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (tvalid_q && tlast_q && M_AXIS_k2h_tready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      slot_q   <= '0;
      acc_q    <= '0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign s_rec_tready      = rec_rdy;
  assign M_AXIS_k2h_tdata  = tdata_q;
  assign M_AXIS_k2h_tkeep  = tkeep_q;
  assign M_AXIS_k2h_tvalid = tvalid_q;
  assign M_AXIS_k2h_tlast  = tlast_q;
  assign M_AXIS_k2h_tdest  = dest_q;

endmodule

// File: tb/tb_md_k2h_packer.sv
// Directed bench for md_k2h_packer: frames of various lengths,
// backpressure, mid-frame reset and start-while-busy.
module tb_md_k2h_packer;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  num_records = '0;
  logic [15:0]  dest_id = '0;
  logic         busy;
  logic         done;
  logic [127:0] s_rec_tdata = '0;
  logic         s_rec_tvalid = 1'b0;
  logic         s_rec_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic [15:0]  m_tdest;
  logic         m_tready = 1'b1;

  md_k2h_packer dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .start             (start),
    .num_records       (num_records),
    .dest_id           (dest_id),
    .busy              (busy),
    .done              (done),
    .s_rec_tdata       (s_rec_tdata),
    .s_rec_tvalid      (s_rec_tvalid),
    .s_rec_tready      (s_rec_tready),
    .M_AXIS_k2h_tdata  (m_tdata),
    .M_AXIS_k2h_tkeep  (m_tkeep),
    .M_AXIS_k2h_tvalid (m_tvalid),
    .M_AXIS_k2h_tlast  (m_tlast),
    .M_AXIS_k2h_tdest  (m_tdest),
    .M_AXIS_k2h_tready (m_tready)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int vcnt = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  int fbase = 0;
  bit rand_rdy = 1'b0;
  bit fix_rdy = 1'b1;

  logic [511:0] q_data[$];
  logic [63:0]  q_keep[$];
  logic         q_last[$];
  logic [15:0]  q_dest[$];

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rec(input int i);
    return {32'(fbase + i), 32'h3000_0000 + 32'(i),
            32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
  endfunction

  always @(posedge ap_clk) begin
    cyc++;
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
  end

  bit           stall_prev = 1'b0;
  logic [511:0] pd;
  logic [63:0]  pk;
  logic         pl;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 512'(m_tvalid), 512'(1));
        chk("stall_data", m_tdata, pd);
        chk("stall_keep", 512'(m_tkeep), 512'(pk));
        chk("stall_last", 512'(m_tlast), 512'(pl));
      end
      stall_prev = m_tvalid && !m_tready;
      pd = m_tdata;
      pk = m_tkeep;
      pl = m_tlast;
      if (m_tvalid) vcnt++;
      if (m_tvalid && m_tready) begin
        q_data.push_back(m_tdata);
        q_keep.push_back(m_tkeep);
        q_last.push_back(m_tlast);
        q_dest.push_back(m_tdest);
        if (m_tlast) hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start(input int n, input logic [15:0] d);
    num_records = 32'(n);
    dest_id = d;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_recs(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      int t = 0;
      s_rec_tdata = rec(i);
      s_rec_tvalid = 1'b1;
      do begin
        @(negedge ap_clk);
        t++;
      end while (!s_rec_tready && t < 200);
      if (!s_rec_tready) chk("rec_timeout", 512'(0), 512'(1));
      @(posedge ap_clk);
      #1;
    end
    s_rec_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge ap_clk);
      #1;
      t++;
    end
    chk("done_seen", 512'(done_cnt - d0), 512'(1));
    chk("done_lat", 512'(done_cyc), 512'(hs_cyc + 1));
    @(negedge ap_clk);
    #1;
    chk("done_pulse", 512'(done), 512'(0));
    chk("busy_clr", 512'(busy), 512'(0));
    chk("done_once", 512'(done_cnt - d0), 512'(1));
  endtask

  task automatic check_frame(input int n, input logic [15:0] d);
    int nb = (n + 3) / 4;
    chk("nbeats", 512'(q_data.size()), 512'(nb));
    for (int j = 0; j < nb && j < q_data.size(); j++) begin
      logic [511:0] ed = '0;
      logic [63:0]  ek = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * j + l < n) begin
          ed[l*128 +: 128] = rec(4 * j + l);
          ek[l*16 +: 16] = 16'hFFFF;
        end
      end
      chk($sformatf("data%0d", j), q_data[j], ed);
      chk($sformatf("keep%0d", j), 512'(q_keep[j]), 512'(ek));
      chk($sformatf("last%0d", j), 512'(q_last[j]), 512'(j == nb - 1));
      chk($sformatf("dest%0d", j), 512'(q_dest[j]), 512'(d));
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_dest.delete();
  endtask

  task automatic run_frame(input int n, input logic [15:0] d);
    int d0 = done_cnt;
    clear_q();
    fbase += 256;
    pulse_start(n, d);
    chk("busy_set", 512'(busy), 512'(1));
    send_recs(0, n);
    wait_done(d0);
    check_frame(n, d);
  endtask

  initial begin
    int d0;
    int v0;
    #2;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_valid", 512'(m_tvalid), 512'(0));
    chk("rst_rready", 512'(s_rec_tready), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    #20;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // T1: two full beats
    run_frame(8, 16'h0005);
    chk("t1_lane0_id", 512'(q_data[0][127:96]), 512'(fbase));

    // T2: partial final beat
    run_frame(5, 16'h00A3);

    // T3: empty frame
    d0 = done_cnt;
    v0 = vcnt;
    pulse_start(0, 16'h0011);
    @(negedge ap_clk);
    #1;
    chk("t3_done", 512'(done), 512'(1));
    @(negedge ap_clk);
    #1;
    chk("t3_done_off", 512'(done), 512'(0));
    chk("t3_busy_off", 512'(busy), 512'(0));
    chk("t3_no_valid", 512'(vcnt), 512'(v0));
    chk("t3_done_cnt", 512'(done_cnt - d0), 512'(1));

    // T4: random backpressure
    rand_rdy = 1'b1;
    run_frame(12, 16'h1234);
    rand_rdy = 1'b0;
    @(posedge ap_clk);
    #1;

    // T5: reset mid-frame
    d0 = done_cnt;
    clear_q();
    fbase += 256;
    pulse_start(10, 16'h0777);
    send_recs(0, 6);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t5_busy", 512'(busy), 512'(0));
    chk("t5_valid", 512'(m_tvalid), 512'(0));
    chk("t5_data", m_tdata, 512'(0));
    chk("t5_keep", 512'(m_tkeep), 512'(0));
    chk("t5_last", 512'(m_tlast), 512'(0));
    chk("t5_dest", 512'(m_tdest), 512'(0));
    chk("t5_rready", 512'(s_rec_tready), 512'(0));
    chk("t5_done", 512'(done), 512'(0));
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    chk("t5_no_done", 512'(done_cnt - d0), 512'(0));
    run_frame(4, 16'h0042);

    // T6: start while busy is ignored
    d0 = done_cnt;
    clear_q();
    fbase += 256;
    pulse_start(8, 16'h0BEE);
    send_recs(0, 2);
    pulse_start(99, 16'hDEAD);
    send_recs(2, 6);
    wait_done(d0);
    check_frame(8, 16'h0BEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
